// File: rtl/rec_dma_pkg.sv
// +-----------------------------------------------------------------------+
// | rec_dma_pkg : shared types and constants for rec_dma_writer           |
// | Optional feature macro: REC_DMA_HEADER_EN                             |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

package rec_dma_pkg;

  localparam int         WORD_BYTES = 4;
  localparam logic [7:0] HDR_MARKER = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_CHECK,
    ST_READ,
    ST_COLLECT,
    ST_WRITE,
    ST_NEXT
`ifdef REC_DMA_HEADER_EN
    , ST_HEADER
`endif
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rec_byte_packer.sv
// +-----------------------------------------------------------------------+
// | rec_byte_packer : little-endian 4-byte capture/shift register         |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module rec_byte_packer #(
  parameter int RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic [31:0] load_data_i,
  input  logic        rd_req_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o
);
  import rec_dma_pkg::*;

  logic [RD_LATENCY-1:0] dly_q;
  logic [31:0]           word_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dly_q  <= '0;
      word_q <= '0;
    end else begin
      dly_q[0] <= rd_req_i;
      for (int i = 1; i < RD_LATENCY; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
      // Bytes enter at the top so the first one ends up in bits [7:0].
      if (load_i) begin
        word_q <= load_data_i;
      end else if (clear_i) begin
        word_q <= '0;
      end else if (dly_q[RD_LATENCY-1]) begin
        word_q <= {byte_i, word_q[31:8]};
      end
    end
  end

  assign word_o = word_q;

endmodule

`default_nettype wire

// File: rtl/rec_dma_writer.sv
// +-----------------------------------------------------------------------+
// | rec_dma_writer : channel scanner draining FIFOs to an Avalon-MM ring  |
// | Optional feature macro: REC_DMA_HEADER_EN (per-block header word)     |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module rec_dma_writer
  import rec_dma_pkg::*;
#(
  parameter int CH_NUM      = 6,
  parameter int BLOCK_BYTES = 64,
  parameter int RD_LATENCY  = 2,
  parameter int SETTLE      = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       buf_words,
  output logic [2:0]        active_channel,
  output logic              dma_rd_req,
  input  logic [7:0]        fifo_q,
  input  logic [7:0]        fifo_usdw,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  output logic [15:0]       wr_ptr,
  output logic              block_done
);

  state_t            state_q;
  logic [7:0]        cnt_q;
  logic [7:0]        bytes_q;
  logic [2:0]        ch_q;
  logic              rd_req_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wr_ptr_q;
  logic              done_q;

  logic [15:0]       wr_ptr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] addr_cur;
  logic [2:0]        ch_d;
  logic              blk_start;
  logic              hdr_load;
  logic [31:0]       hdr_word;

  assign wr_ptr_d  = (wr_ptr_q >= buf_words - 16'd1) ? 16'd0 : wr_ptr_q + 16'd1;
  assign addr_d    = base_addr + ADDR_W'({wr_ptr_d, 2'b00});
  assign addr_cur  = base_addr + ADDR_W'({wr_ptr_q, 2'b00});
  assign ch_d      = (ch_q == 3'(CH_NUM - 1)) ? 3'd0 : ch_q + 3'd1;
  assign blk_start = (state_q == ST_CHECK) && (fifo_usdw >= 8'(BLOCK_BYTES));

`ifdef REC_DMA_HEADER_EN
  logic [15:0] seq_q;
  assign hdr_load = blk_start;
  assign hdr_word = {HDR_MARKER, 5'b0, ch_q, seq_q};
`else
  assign hdr_load = 1'b0;
  assign hdr_word = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bytes_q  <= '0;
      ch_q     <= '0;
      rd_req_q <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= base_addr;
      wr_ptr_q <= '0;
      done_q   <= 1'b0;
`ifdef REC_DMA_HEADER_EN
      seq_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          addr_q <= addr_cur;
          cnt_q  <= '0;
          if (enable) state_q <= ST_SELECT;
        end
        ST_SELECT: begin
          if (int'(cnt_q) + 1 >= SETTLE) state_q <= ST_CHECK;
          else cnt_q <= cnt_q + 8'd1;
        end
        ST_CHECK: begin
          cnt_q <= '0;
          if (blk_start) begin
            bytes_q <= 8'(BLOCK_BYTES);
`ifdef REC_DMA_HEADER_EN
            write_q <= 1'b1;
            state_q <= ST_HEADER;
`else
            rd_req_q <= 1'b1;
            state_q  <= ST_READ;
`endif
          end else begin
            state_q <= ST_NEXT;
          end
        end
`ifdef REC_DMA_HEADER_EN
        ST_HEADER: begin
          if (!avm_waitrequest) begin
            write_q  <= 1'b0;
            wr_ptr_q <= wr_ptr_d;
            addr_q   <= addr_d;
            seq_q    <= seq_q + 16'd1;
            rd_req_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= ST_READ;
          end
        end
`endif
        ST_READ: begin
          if (cnt_q == 8'(WORD_BYTES - 1)) begin
            rd_req_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= ST_COLLECT;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_COLLECT: begin
          // The last byte lands in the packer on the same edge that raises avm_write.
          if (int'(cnt_q) + 1 >= RD_LATENCY) begin
            write_q <= 1'b1;
            state_q <= ST_WRITE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_WRITE: begin
          if (!avm_waitrequest) begin
            write_q  <= 1'b0;
            wr_ptr_q <= wr_ptr_d;
            addr_q   <= addr_d;
            bytes_q  <= bytes_q - 8'(WORD_BYTES);
            cnt_q    <= '0;
            if (bytes_q != 8'(WORD_BYTES)) begin
              rd_req_q <= 1'b1;
              state_q  <= ST_READ;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          ch_q    <= ch_d;
          cnt_q   <= '0;
          state_q <= enable ? ST_SELECT : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  rec_byte_packer #(
    .RD_LATENCY(RD_LATENCY)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (blk_start),
    .load_i     (hdr_load),
    .load_data_i(hdr_word),
    .rd_req_i   (rd_req_q),
    .byte_i     (fifo_q),
    .word_o     (avm_writedata)
  );

  assign active_channel = ch_q;
  assign dma_rd_req     = rd_req_q;
  assign avm_write      = write_q;
  assign avm_address    = addr_q;
  assign avm_byteenable = 4'hF;
  assign wr_ptr         = wr_ptr_q;
  assign block_done     = done_q;

endmodule

`default_nettype wire

// File: doc/rec_dma_writer.md
# rec_dma_writer

Downstream consumer of the receive channel switch. Rotates `active_channel` over the receive channels, checks the selected FIFO fill level, and drains one fixed-size block per visit through `dma_rd_req`. Packs the returned bytes little-endian into 32-bit words and writes them over an Avalon-MM write master into a circular buffer in system memory.

## Interface
Parameters:
- `CH_NUM`, 6: number of channels scanned, 1..8.
- `BLOCK_BYTES`, 64: bytes drained per channel visit. Multiple of 4, range 4..252.
- `RD_LATENCY`, 2: cycles from `dma_rd_req` high to the byte valid on `fifo_q`. Covers the FIFO read plus the switch output register.
- `SETTLE`, 2: cycles to wait after an `active_channel` change before sampling `fifo_usdw`.
- `ADDR_W`, 32: Avalon address width.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  run the channel scan. Sampled only in IDLE and NEXT.
- `base_addr`  in  ADDR_W  byte address of the circular buffer. Must be 4-byte aligned.
- `buf_words`  in  16  circular buffer size in 32-bit words. Must be ≥1.
- `active_channel`  out  3  channel select to the switch.
- `dma_rd_req`  out  1  one-byte read strobe to the switch.
- `fifo_q`  in  8  selected channel data.
- `fifo_usdw`  in  8  selected channel fill level.
- `avm_address`  out  ADDR_W  write address.
- `avm_write`  out  1  write request.
- `avm_writedata`  out  32  packed word.
- `avm_byteenable`  out  4  constant 4'hF.
- `avm_waitrequest`  in  1  slave stall.
- `wr_ptr`  out  16  next word index in the buffer.
- `block_done`  out  1  one-cycle pulse after the last word of a block is accepted.

## Operation
State machine:
- **IDLE:** go to SELECT when `enable`=1.
- **SELECT:** hold `active_channel` stable and count `SETTLE` cycles, then go to CHECK.
- **CHECK:**
  - If `fifo_usdw` ≥ `BLOCK_BYTES`, load the byte counter with `BLOCK_BYTES` and go to READ.
  - Otherwise skip the channel and go to NEXT. No partial blocks are ever drained.
- **READ:** assert `dma_rd_req` for exactly 4 consecutive cycles, then go to COLLECT.
- **COLLECT:** capture 4 bytes, then go to WRITE. The byte for the k-th request (k=0..3) is captured `RD_LATENCY` cycles after that request, into `avm_writedata[8k+7:8k]`.
- **WRITE:**
  - Assert `avm_write` and hold address and data until a cycle with `avm_waitrequest`=0.
  - On acceptance, advance `wr_ptr` and subtract 4 from the byte counter.
  - If the counter is nonzero, go to READ. Otherwise pulse `block_done` and go to NEXT.
- **NEXT:** advance `active_channel` modulo `CH_NUM` (`CH_NUM`-1 → 0). Go to SELECT if `enable`=1, else IDLE.

Addressing:
- `avm_address` = `base_addr` + 4·`wr_ptr`. Computed in ADDR_W bits; overflow wraps silently.
- `wr_ptr` wraps from `buf_words`-1 to 0.

Boundary cases:
- Deasserting `enable` mid-block does not abort. The block completes, then the FSM enters IDLE.
- `fifo_usdw` is checked only in CHECK. During a block, the FIFO is guaranteed to hold enough bytes.
- A `buf_words` change takes effect at the next wrap compare. No re-alignment is performed.
- With `CH_NUM`=1, `active_channel` stays at 0 and SELECT still waits `SETTLE` cycles.

## Timing
- All outputs are registered.
- Reset values: `active_channel`=0, `dma_rd_req`=0, `avm_write`=0, `avm_writedata`=0, `avm_address`=`base_addr`, `wr_ptr`=0, `block_done`=0, state IDLE.
- Reset mid-operation abandons any partial word and drops `avm_write` in the same cycle.
- Per-word cost: 4 (READ) + `RD_LATENCY` (COLLECT) + 1 (WRITE) cycles plus waitrequest stalls. This is 7 cycles with the defaults.
- Channel turn overhead: 1 (NEXT) + `SETTLE` + 1 (CHECK) cycles.
- `block_done` is high in the cycle after the final word is accepted.

## Configuration
Macro `REC_DMA_HEADER_EN`.

Defined:
- Before each drained block, write one header word = {8'hA5, 5'b0, channel[2:0], seq[15:0]}.
- `seq` is a 16-bit counter of blocks written. It resets to 0 and wraps.
- The header uses the same WRITE handshake and consumes one `wr_ptr` slot.
- Skipped channels produce no header.

Undefined:
- No header is written and no `seq` counter is synthesized.

## Structure
- Package `rec_dma_pkg` holds:
  - the state enum (IDLE, SELECT, CHECK, READ, COLLECT, WRITE, NEXT, plus HEADER under the macro);
  - the header marker constant 8'hA5;
  - the word-size constant 4.
- Sub-module `rec_byte_packer` holds the 4-byte shift and capture register. It is driven by a delayed copy of `dma_rd_req` with `RD_LATENCY` stages and clears on block start.

## Test plan
- Channel 2 with `fifo_usdw`=64 and bytes 0x00..0x3F → 16 writes. First word is 0x03020100 at `base_addr`+0, last is 0x3F3E3D3C. One `block_done` pulse, then `active_channel`=3.
- All channels with `fifo_usdw`=63 → no `dma_rd_req` or `avm_write`. `active_channel` cycles 0..5..0 with a period of 6·(`SETTLE`+2) cycles.
- `buf_words`=20 with two full blocks → the second block's words 4..15 land at indices 0..11. `wr_ptr` ends at 12.
- `avm_waitrequest` held high 5 cycles on the 3rd word → address and data stable throughout. No extra reads are issued and the word is accepted exactly once.
- `reset` pulsed in COLLECT of word 5 → all outputs reach their reset values the next cycle. After `enable`, the restart is at channel 0 with `wr_ptr`=0.
- With `REC_DMA_HEADER_EN`, two blocks on channel 4 → headers 0xA5040000 then 0xA5040001. Each block occupies 17 words.
